// File: rtl/tuart_rx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tuart_rx_if
// Purpose  : Serial-in / byte-out bundle between the tuart_rx receiver and
//            the logIP command decoder.
//   rx_i         serial line, idle high, asynchronous to the receiver clock
//   data_o       last correctly received word
//   valid_o      one-cycle strobe, data_o is new in the same cycle
//   frame_err_o  one-cycle strobe, stop bit sampled low
//   parity_err_o one-cycle strobe, parity mismatch (parity build only)
//   busy_o       high while a frame is in progress
// Modports : master = receiver side, slave = line driver / byte consumer
// Revision : 1.0  initial release
// ============================================================================
interface tuart_rx_if #(
    parameter int WORD_BITS = 8
);
    logic                 rx_i;
    logic [WORD_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 frame_err_o;
    logic                 parity_err_o;
    logic                 busy_o;

    modport master (
        input  rx_i,
        output data_o, valid_o, frame_err_o, parity_err_o, busy_o
    );

    modport slave (
        output rx_i,
        input  data_o, valid_o, frame_err_o, parity_err_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/tuart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tuart_rx
// Purpose  : UART receiver. Deserialises 8N1 frames (8E1 when
//            TUART_RX_PARITY_EN is defined) into parallel words, sampling
//            each bit once at its centre. Flags false starts, framing
//            errors and (optionally) parity errors.
// Ports    : clk_i   system clock, rising edge
//            rst_in  asynchronous active-low reset
//            bus     tuart_rx_if.master (rx_i in; data_o, valid_o,
//                    frame_err_o, parity_err_o, busy_o out)
// Macro    : TUART_RX_PARITY_EN - adds an even-parity bit between the data
//            bits and the stop bit; undefined gives plain 8N1 with
//            parity_err_o tied low.
// Revision : 1.0  initial release
// ============================================================================
module tuart_rx #(
    parameter int CLK_PER_BIT = 868,
    parameter int WORD_BITS   = 8
) (
    input  wire logic   clk_i,
    input  wire logic   rst_in,
    tuart_rx_if.master  bus
);
    localparam int c_CW = $clog2(CLK_PER_BIT);
    localparam int c_IW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CLK_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(CLK_PER_BIT / 2);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef TUART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // Two-flop synchroniser; idle-high reset so no false start after reset.
    logic [1:0]           r_sync;
    logic                 w_rx_s;

    state_t               r_state, w_state_nxt;
    logic [c_CW-1:0]      r_cnt,   w_cnt_nxt;
    logic [c_IW-1:0]      r_idx,   w_idx_nxt;
    logic [WORD_BITS-1:0] r_shift, w_shift_nxt;
    logic [WORD_BITS-1:0] r_data,  w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_ferr,  w_ferr_nxt;
`ifdef TUART_RX_PARITY_EN
    logic                 r_par,   w_par_nxt;
    logic                 r_perr,  w_perr_nxt;
`endif

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef TUART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_sync  <= {r_sync[0], bus.rx_i};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef TUART_RX_PARITY_EN
            r_par   <= w_par_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef TUART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_perr_nxt  = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) w_state_nxt = S_START;
            end
            // The start bit is re-checked half a bit in; this both rejects
            // glitches and sets the phase of every later centre sample.
            S_START: begin
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    if (r_idx == c_IDX_LAST) begin
                        w_idx_nxt   = '0;
`ifdef TUART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
`ifdef TUART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = w_rx_s;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            // Leaving at mid-stop-bit lets a back-to-back start edge be
            // caught at its true position.
            S_STOP: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_BREAK;
`ifdef TUART_RX_PARITY_EN
                    end else if (^{r_shift, r_par}) begin
                        w_perr_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
`endif
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = r_shift;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            // A held-low line must not restart reception until it idles.
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.data_o      = r_data;
    assign bus.valid_o     = r_valid;
    assign bus.frame_err_o = r_ferr;
    assign bus.busy_o      = (r_state != S_IDLE);
`ifdef TUART_RX_PARITY_EN
    assign bus.parity_err_o = r_perr;
`else
    assign bus.parity_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tuart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tuart_rx
// Purpose  : Self-checking bench for tuart_rx at CLK_PER_BIT=16, WORD_BITS=8.
//            Each driven frame pushes its expected strobe (kind, data and
//            cycle) to a queue; a monitor pops and compares on every strobe.
// Revision : 1.0  initial release
// ============================================================================
module tb_tuart_rx;
    localparam int N = 16;
`ifdef TUART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int LAT    = 3 + N/2 + 10*N;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int LAT    = 3 + N/2 + 9*N;
`endif
    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] last_good = 8'h00;
    exp_t       q[$];

    tuart_rx_if #(.WORD_BITS(8)) bus ();

    tuart_rx #(
        .CLK_PER_BIT (N),
        .WORD_BITS   (8)
    ) dut (
        .clk_i  (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called just after a rising edge; holds the bit for N edges.
    task automatic send_bit(input logic b);
        bus.rx_i = b;
        repeat (N) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rx_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
        exp_t e;
        e.cyc = cyc + 1 + LAT;
        if (!stop) begin
            e.kind = K_FERR;
            e.data = last_good;
        end else if (PAR_EN && ((^b) ^ par)) begin
            e.kind = K_PERR;
            e.data = last_good;
        end else begin
            e.kind    = K_VALID;
            e.data    = b;
            last_good = b;
        end
        q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (PAR_EN) send_bit(par);
        send_bit(stop);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (bus.valid_o || bus.frame_err_o || bus.parity_err_o)) begin
            exp_t e;
            int   k;
            k = bus.valid_o ? K_VALID : (bus.frame_err_o ? K_FERR : K_PERR);
            chk("onehot", 32'($countones({bus.valid_o, bus.frame_err_o, bus.parity_err_o})), 32'd1);
            if (q.size() == 0) begin
                chk("unexpected_strobe", 32'(k), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("kind", 32'(k), 32'(e.kind));
                chk("data", 32'(bus.data_o), 32'(e.data));
                chk("cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int e0;
        rst_n    = 1'b0;
        bus.rx_i = 1'b1;

        // Reset with the line toggling
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.rx_i = ~bus.rx_i;
        end
        @(negedge clk);
        chk("rst_data",  32'(bus.data_o), 32'd0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_ferr",  32'(bus.frame_err_o), 32'd0);
        chk("rst_perr",  32'(bus.parity_err_o), 32'd0);
        chk("rst_busy",  32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        bus.rx_i = 1'b1;
        rst_n    = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;

        // Single byte
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(20);

        // Back-to-back, zero idle time
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        send_frame(8'h55, 1'b1, ^8'h55);
        idle(20);

        // Glitch: 4 low cycles
        e0 = cyc + 1;
        bus.rx_i = 1'b0;
        repeat (4) @(posedge clk); #1;
        bus.rx_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_hi", 32'(bus.busy_o), 32'd1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("glitch_cyc", 32'(cyc), 32'(e0 + 12));
        chk("glitch_busy_lo", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        idle(20);

        // Framing error followed by a break
        send_frame(8'h3C, 1'b0, ^8'h3C);
        repeat (24) @(posedge clk);
        @(negedge clk);
        chk("break_busy", 32'(bus.busy_o), 32'd1);
        repeat (24) @(posedge clk); #1;
        idle(20);
        @(negedge clk);
        chk("break_data_hold", 32'(bus.data_o), 32'(last_good));
        chk("break_busy_lo", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        send_frame(8'h81, 1'b1, ^8'h81);
        idle(20);

        // Reset mid-frame during data bit 3 of 0x96
        begin
            logic [7:0] b;
            b = 8'h96;
            send_bit(1'b0);
            for (int i = 0; i < 3; i++) send_bit(b[i]);
            bus.rx_i = b[3];
            repeat (8) @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            chk("midrst_busy",  32'(bus.busy_o), 32'd0);
            chk("midrst_valid", 32'(bus.valid_o), 32'd0);
            chk("midrst_data",  32'(bus.data_o), 32'd0);
            last_good = 8'h00;
            bus.rx_i = 1'b1;
            repeat (3) @(posedge clk); #1;
            rst_n = 1'b1;
            idle(20);
            send_frame(b, 1'b1, ^b);
            idle(20);
        end

`ifdef TUART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
`endif

        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        idle(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
